// File: rtl/cp0_exc_controller_if.sv
// Commit-stage bundle between the pipeline (master) and the CP0 exception controller (slave).
// Holds the instruction-commit, exception and interrupt-request signals, plus the redirect and read-back returns.
interface cp0_exc_controller_if #(
  parameter int NUM_IRQ = 6
);
  logic               stall;
  logic               inst_valid;
  logic               is_mtc0;
  logic               is_mfc0;
  logic               is_eret;
  logic [4:0]         cp0_addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic               exc_bd;
  logic [31:0]        exc_pc;
  logic [NUM_IRQ-1:0] irq_in;
  logic               take_handler;
  logic [31:0]        handler_pc;
  logic               eret_taken;
  logic [31:0]        epc_out;

  modport master (
    output stall, inst_valid, is_mtc0, is_mfc0, is_eret, cp0_addr, wdata,
           exc_valid, exc_code, exc_bd, exc_pc, irq_in,
    input  rdata, take_handler, handler_pc, eret_taken, epc_out
  );

  modport slave (
    input  stall, inst_valid, is_mtc0, is_mfc0, is_eret, cp0_addr, wdata,
           exc_valid, exc_code, exc_bd, exc_pc, irq_in,
    output rdata, take_handler, handler_pc, eret_taken, epc_out
  );
endinterface

// File: rtl/cp0_exc_controller.sv
// CP0 SR/Cause/EPC/PRId and exception/interrupt arbitration at commit; redirects are same-cycle,
// register effects land at the next edge, and stall freezes everything except the IRQ synchroniser.
module cp0_exc_controller #(
  parameter int          NUM_IRQ         = 6,
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter logic [31:0] HANDLER_ADDR    = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE      = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  reset,
  cp0_exc_controller_if.slave  bus
);

  logic [IRQ_SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;

  logic [NUM_IRQ-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [4:0]         exccode_q, exccode_d;
  logic [31:0]        epc_q, epc_d;

  logic [NUM_IRQ-1:0] ip;
  logic               int_req;
  logic               commit_ok;
  logic               take;
  logic               eret_go;
  logic               mtc0_go;
  logic [31:0]        sr_val;
  logic [31:0]        cause_val;

  // The last synchroniser stage is Cause.IP itself, so irq_in reaches IP in IRQ_SYNC_STAGES cycles.
  assign ip = sync_q[IRQ_SYNC_STAGES-1];

  assign int_req   = (|(ip & im_q)) & ie_q & ~exl_q;
  assign commit_ok = reset & ~bus.stall & bus.inst_valid;
  assign take      = commit_ok & (int_req | bus.exc_valid);
  assign eret_go   = commit_ok & ~take & bus.is_eret;
  assign mtc0_go   = commit_ok & ~take & bus.is_mtc0;

  assign bus.take_handler = take;
  assign bus.handler_pc   = HANDLER_ADDR;
  assign bus.eret_taken   = eret_go;
  assign bus.epc_out      = epc_q;

  always_comb begin
    sr_val                   = '0;
    sr_val[10 +: NUM_IRQ]    = im_q;
    sr_val[1]                = exl_q;
    sr_val[0]                = ie_q;
    cause_val                = '0;
    cause_val[31]            = bd_q;
    cause_val[10 +: NUM_IRQ] = ip;
    cause_val[6:2]           = exccode_q;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.is_mfc0) begin
      case (bus.cp0_addr)
        5'd12:   bus.rdata = sr_val;
        5'd13:   bus.rdata = cause_val;
        5'd14:   bus.rdata = epc_q;
        5'd15:   bus.rdata = PRID_VALUE;
        default: bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (take) begin
      exl_d     = 1'b1;
      bd_d      = bus.exc_bd;
      exccode_d = int_req ? 5'd0 : bus.exc_code;
      epc_d     = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
    end else if (eret_go) begin
      exl_d = 1'b0;
    end else if (mtc0_go) begin
      // Cause and PRId are not software-writable; only SR and EPC accept mtc0.
      case (bus.cp0_addr)
        5'd12: begin
          im_d  = bus.wdata[10 +: NUM_IRQ];
          exl_d = bus.wdata[1];
          ie_d  = bus.wdata[0];
        end
        5'd14:   epc_d = bus.wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: doc/cp0_exc_controller.md
Name: cp0_exc_controller

Overview:
- Parametrised CP0 register file and exception/interrupt controller for the MIPS pipeline, sitting at the commit (M/W boundary) stage.
- Owns SR(12), Cause(13), EPC(14) and PRId(15), and services mtc0/mfc0/eret.
- Synchronises external interrupt lines, arbitrates interrupts against in-flight exceptions, and redirects the PC to the handler.
- Generalises the earlier combinational submitter: configurable IRQ count, synchroniser depth, handler vector, PRId, a registered state update, and a commit-stall qualifier.

Parameters:
NUM_IRQ, 6, number of hardware interrupt lines, range 1..6, mapped to IP/IM bits [10+NUM_IRQ-1:10]
IRQ_SYNC_STAGES, 2, flops in each irq_in synchroniser chain, range 1..3
HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
PRID_VALUE, 32'h0000_0000, read-only PRId contents

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state
stall  in  1  commit slot frozen; blocks all architectural updates and redirects
inst_valid  in  1  commit slot holds a real instruction (not a bubble)
is_mtc0  in  1  committing instruction is mtc0
is_mfc0  in  1  committing instruction is mfc0
is_eret  in  1  committing instruction is eret
cp0_addr  in  5  rd field of mtc0/mfc0
wdata  in  32  rt value for mtc0
rdata  out  32  mfc0 read data, combinational
exc_valid  in  1  committing instruction raised a synchronous exception
exc_code  in  5  ExcCode of that exception
exc_bd  in  1  committing instruction sits in a branch delay slot
exc_pc  in  32  PC of the committing instruction
irq_in  in  NUM_IRQ  asynchronous level interrupt requests
take_handler  out  1  redirect PC to handler_pc this cycle, flush younger stages
handler_pc  out  32  constant HANDLER_ADDR
eret_taken  out  1  redirect PC to epc_out this cycle
epc_out  out  32  current EPC

Behaviour:
- Reset (reset==0 at edge): SR=0, Cause=0, EPC=0, all synchroniser flops=0.
- While reset==0: take_handler=0 and eret_taken=0. rdata still reflects register contents.
- SR layout: IM[10+NUM_IRQ-1:10], EXL[1], IE[0]. All other bits read 0.
- Cause layout: BD[31], IP[10+NUM_IRQ-1:10], ExcCode[6:2]. All other bits read 0.
- Synchroniser:
  - Each irq_in bit passes through IRQ_SYNC_STAGES flops every cycle, independent of stall.
  - Cause.IP is loaded from the final stage every cycle.
  - Latency from irq_in to Cause.IP is IRQ_SYNC_STAGES cycles.
- int_req = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL, using registered values.
- take = ~stall & inst_valid & (int_req | exc_valid). This is combinational; take_handler = take.
- Interrupt has priority over exc_valid when both are present; ExcCode is then 0 (Int).
- On take, at the next edge:
  - SR.EXL<=1; IE and IM are unchanged.
  - Cause.BD<=exc_bd; Cause.ExcCode<=(int_req ? 0 : exc_code).
  - EPC<=(exc_bd ? exc_pc-4 : exc_pc), 32-bit wrap.
  - Any same-cycle mtc0 or eret is suppressed (no write, eret_taken=0).
- eret (not take, ~stall, inst_valid, is_eret):
  - eret_taken=1 combinationally; epc_out=EPC.
  - SR.EXL<=0 at the edge.
  - Legal even when EXL=0.
- mtc0 (not take, ~stall, inst_valid, is_mtc0), written at the edge:
  - addr 12: IM, EXL, IE written from wdata; other bits are dropped.
  - addr 14: EPC<=wdata.
  - addr 13, addr 15, and all other addresses: write ignored. Cause.IP stays hardware-owned.
- mfc0: rdata = register at cp0_addr (pre-edge value); unmapped addresses read 0. rdata is produced whenever is_mfc0 is asserted, irrespective of stall.
- stall=1: no SR, EPC, BD or ExcCode change; take_handler=0, eret_taken=0. The synchroniser and IP keep running.
- An interrupt pending during EXL=1 is held in IP. It is taken on the first valid, unstalled commit after eret clears EXL, i.e. the handler is re-entered one cycle after eret if the request is still asserted.
- IP is level-sensitive, not latched: a request that deasserts before it is taken is lost.
- Reset mid-handler: EXL cleared, pending state discarded.
- Latency summary: redirect is same-cycle; register effects are visible on the next cycle.

Test Plan:
- Reset: hold reset=0 for 2 edges with irq_in all ones -> SR=Cause=EPC=0, take_handler=0. After release, Cause.IP=6'h3F after 2 cycles (default params).
- mtc0 SR then interrupt:
  - Write SR=32'h0000_0401, then irq_in[0]=1 with inst_valid=1, exc_pc=32'h3010.
  - take_handler=1 on the cycle IP[10] appears.
  - Next cycle: EPC=32'h3010, ExcCode=0, EXL=1, mfc0 12 -> 32'h0000_0403.
- Delay-slot exception: exc_valid=1, exc_code=5'd10, exc_bd=1, exc_pc=32'h3024 -> EPC=32'h3020, Cause=32'h8000_0028 (IP=0).
- Simultaneous events: int_req and exc_valid (code 4) with is_mtc0 to addr 14 in the same cycle -> ExcCode=0, EPC=exc_pc, the mtc0 EPC write is discarded.
- Stall and bubble gating: pending interrupt with stall=1 for 3 cycles -> no take, no state change; stall=0 with inst_valid=0 -> no take; next valid commit -> take.
- eret and re-entry: in handler with irq held high, eret -> eret_taken=1, epc_out=EPC, EXL=0 next cycle, take_handler=1 on the following valid commit. mtc0 to addr 13 (wdata=32'hFFFF_FFFF) leaves Cause unchanged.
